// File: rtl/round_sched_pkg.sv
// round_sched_pkg: shared types for the round scheduler.
//   state_t : job sequencer states IDLE, SYNC, LAUNCH, WAIT, PULL, DONE.
package round_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LAUNCH,
        WAIT,
        PULL,
        DONE
    } state_t;

endpackage

// File: rtl/round_scheduler_if.sv
// round_scheduler_if: host/gate-array handshake bundle for round_scheduler.
//   master modport : host side (drives job request, abort and gate readies)
//   slave modport  : scheduler side (drives busy/pulses/round count/done/err)
// Signals
//   i_req, i_rounds, i_gate_en, i_abort, i_tx_ready, i_rx_ready : toward scheduler
//   o_busy, o_gen_sync, o_tx_start, o_rx_pull, o_round_cnt,
//   o_done, o_err                                              : from scheduler
interface round_scheduler_if #(
    parameter int GATE_NUMBER = 8,
    parameter int ROUND_W     = 16
);
    logic                   i_req;
    logic [ROUND_W-1:0]     i_rounds;
    logic [GATE_NUMBER-1:0] i_gate_en;
    logic                   i_abort;
    logic [GATE_NUMBER-1:0] i_tx_ready;
    logic [GATE_NUMBER-1:0] i_rx_ready;
    logic                   o_busy;
    logic                   o_gen_sync;
    logic                   o_tx_start;
    logic                   o_rx_pull;
    logic [ROUND_W-1:0]     o_round_cnt;
    logic                   o_done;
    logic                   o_err;

    modport master (
        output i_req, i_rounds, i_gate_en, i_abort, i_tx_ready, i_rx_ready,
        input  o_busy, o_gen_sync, o_tx_start, o_rx_pull, o_round_cnt, o_done, o_err
    );

    modport slave (
        input  i_req, i_rounds, i_gate_en, i_abort, i_tx_ready, i_rx_ready,
        output o_busy, o_gen_sync, o_tx_start, o_rx_pull, o_round_cnt, o_done, o_err
    );

endinterface

// File: rtl/round_sched_timer.sv
// round_sched_timer: per-round WAIT watchdog for round_scheduler.
//   clk     in  : clock
//   rst     in  : synchronous active-high reset
//   load    in  : clear the count (asserted while launching a round)
//   enable  in  : count one WAIT cycle
//   expired out : high during the TIMEOUT_CYCLES-th consecutive enabled cycle
module round_sched_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // count holds the number of WAIT cycles already elapsed, so the current
    // cycle is the last allowed one when count reaches TIMEOUT_CYCLES-1.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/round_scheduler.sv
// round_scheduler: job-level sequencer for the gate array sync/launch/pull path.
// Accepts a job (round count + gate mask), issues one gen_sync, then per round
// one tx_start, waits for every enabled gate's tx/rx ready and issues rx_pull.
// Reports done (pulse) and a sticky err (abort / timeout).
// Ports
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : i_req, i_rounds, i_gate_en, i_abort, i_tx_ready, i_rx_ready in;
//                  o_busy, o_gen_sync, o_tx_start, o_rx_pull, o_round_cnt,
//                  o_done, o_err out (all registered, Moore-decoded from state)
// Configuration
//   ROUND_SCHED_TIMEOUT_EN : when defined, a WAIT lasting TIMEOUT_CYCLES cycles
//                            without all gates ready ends the job with o_err.
module round_scheduler
    import round_sched_pkg::*;
#(
    parameter int GATE_NUMBER    = 8,
    parameter int ROUND_W        = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst,
    round_scheduler_if.slave   bus
);

    state_t                 state;
    state_t                 state_nxt;
    logic [ROUND_W-1:0]     rounds_q;
    logic [GATE_NUMBER-1:0] mask_q;
    logic [ROUND_W-1:0]     cnt_q;
    logic [ROUND_W-1:0]     cnt_inc;
    logic                   err_q;
    logic                   busy_q;
    logic                   gen_sync_q;
    logic                   tx_start_q;
    logic                   rx_pull_q;
    logic                   done_q;
    logic                   all_ready;
    logic                   active;
    logic                   wait_expired;
    logic                   timeout_hit;

`ifdef ROUND_SCHED_TIMEOUT_EN
    round_sched_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .load    (state == LAUNCH),
        .enable  (state == WAIT),
        .expired (wait_expired)
    );
`else
    // No watchdog: WAIT holds until the gates are ready or the job is aborted.
    // The comparison is constant-false for any legal TIMEOUT_CYCLES.
    assign wait_expired = (TIMEOUT_CYCLES < 0);
`endif

    // Masked-off gates count as ready; an all-zero mask is ready immediately.
    assign all_ready   = &((bus.i_tx_ready & bus.i_rx_ready) | ~mask_q);
    assign cnt_inc     = cnt_q + ROUND_W'(1);
    assign active      = (state == SYNC) || (state == LAUNCH) ||
                         (state == WAIT) || (state == PULL);
    // Readiness on the final allowed WAIT cycle still wins over the timeout.
    assign timeout_hit = (state == WAIT) && wait_expired && !all_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.i_req) begin
                    state_nxt = (bus.i_rounds == '0) ? DONE : SYNC;
                end
            end
            SYNC:   state_nxt = bus.i_abort ? DONE : LAUNCH;
            LAUNCH: state_nxt = bus.i_abort ? DONE : WAIT;
            WAIT: begin
                if (bus.i_abort) begin
                    state_nxt = DONE;
                end else if (all_ready) begin
                    state_nxt = PULL;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            PULL: begin
                if (bus.i_abort || (cnt_inc == rounds_q)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = LAUNCH;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each one is a register that
    // is high for exactly the cycle spent in the corresponding state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            rounds_q   <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            gen_sync_q <= 1'b0;
            tx_start_q <= 1'b0;
            rx_pull_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy_q     <= (state_nxt != IDLE);
            gen_sync_q <= (state_nxt == SYNC);
            tx_start_q <= (state_nxt == LAUNCH);
            rx_pull_q  <= (state_nxt == PULL);
            done_q     <= (state_nxt == DONE);

            if ((state == IDLE) && bus.i_req) begin
                rounds_q <= bus.i_rounds;
                mask_q   <= bus.i_gate_en;
                cnt_q    <= '0;
                err_q    <= 1'b0;
            end

            // The round is counted even when an abort lands in PULL.
            if (state == PULL) begin
                cnt_q <= cnt_inc;
            end

            if ((active && bus.i_abort) || timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_gen_sync  = gen_sync_q;
    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_rx_pull   = rx_pull_q;
    assign bus.o_round_cnt = cnt_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_round_scheduler.sv
// tb_round_scheduler: self-checking bench for round_scheduler.
// Each job is driven cycle by cycle; the expected pulse timeline is then
// derived from the recorded per-cycle gate readiness using the job rules
// (sync at 1, launch at 2, pull one cycle after the first ready WAIT cycle,
// next launch right after, done after the last pull, abort truncation).
`timescale 1ns/1ps
module tb_round_scheduler;

    localparam int GN  = 8;
    localparam int RW  = 16;
    localparam int TO  = 16;
    localparam int LIM = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    round_scheduler_if #(.GATE_NUMBER(GN), .ROUND_W(RW)) bus ();

    round_scheduler #(
        .GATE_NUMBER    (GN),
        .ROUND_W        (RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [LIM-1:0] obs, input logic [LIM-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [RW-1:0] rounds, input logic [GN-1:0] mask,
                         input logic abort, input logic [GN-1:0] rdy);
        @(posedge clk);
        #1;
        bus.i_req      = req;
        bus.i_rounds   = rounds;
        bus.i_gate_en  = mask;
        bus.i_abort    = abort;
        bus.i_tx_ready = rdy;
        bus.i_rx_ready = rdy;
        @(negedge clk);
    endtask

    task automatic run_job(input string name, input logic [RW-1:0] rounds, input logic [GN-1:0] mask,
                           input bit fixed, input logic [GN-1:0] fix_rdy, input int abort_c,
                           output int done_at, output logic [RW-1:0] cnt_end, output logic err_end);
        logic [LIM-1:0] o_sync, o_tx, o_pull, o_done, o_busy;
        logic [LIM-1:0] e_sync, e_tx, e_pull, e_done, e_busy;
        logic [RW-1:0]  o_cnt [LIM];
        logic           o_err [LIM];
        bit             ok [LIM];
        logic [GN-1:0]  tx, rx;
        int last, dseen, done_c, launch, bad, pc;
        logic [RW-1:0]  bo, be;
        logic           eo, ee, err_x;

        o_sync = '0; o_tx = '0; o_pull = '0; o_done = '0; o_busy = '0;
        for (int c = 0; c < LIM; c++) begin
            ok[c] = 1'b0; o_cnt[c] = '0; o_err[c] = 1'b0;
        end
        last = LIM - 1;
        dseen = -1;

        for (int c = 0; c < LIM; c++) begin
            @(posedge clk);
            #1;
            bus.i_req = (c <= 1);
            if (c == 0) begin
                bus.i_rounds  = rounds;
                bus.i_gate_en = mask;
            end else begin
                bus.i_rounds  = RW'($urandom_range(0, 7));
                bus.i_gate_en = GN'($urandom);
            end
            bus.i_abort = (c == abort_c);
            if (fixed) begin
                tx = fix_rdy; rx = fix_rdy;
            end else if ($urandom_range(0, 3) == 0) begin
                tx = GN'($urandom); rx = GN'($urandom);
            end else begin
                tx = mask | GN'($urandom); rx = mask | GN'($urandom);
            end
            bus.i_tx_ready = tx;
            bus.i_rx_ready = rx;
            ok[c] = ((tx & rx) | ~mask) == '1;
            @(negedge clk);
            o_sync[c] = bus.o_gen_sync;
            o_tx[c]   = bus.o_tx_start;
            o_pull[c] = bus.o_rx_pull;
            o_done[c] = bus.o_done;
            o_busy[c] = bus.o_busy;
            o_cnt[c]  = bus.o_round_cnt;
            o_err[c]  = bus.o_err;
            if (bus.o_done && dseen < 0) dseen = c;
            if (dseen >= 0 && c == dseen + 2) begin
                last = c;
                break;
            end
        end
        bus.i_req = 1'b0;
        bus.i_abort = 1'b0;

        // Expected timeline from the job rules.
        e_sync = '0; e_tx = '0; e_pull = '0; e_done = '0; e_busy = '0;
        done_c = -1;
        err_x = 1'b0;
        if (rounds == '0) begin
            done_c = 1;
        end else begin
            e_sync[1] = 1'b1;
            launch = 2;
            for (int r = 0; r < int'(rounds); r++) begin
                int w;
                bit timed;
                if (launch >= LIM) break;
                e_tx[launch] = 1'b1;
                w = launch + 1;
                timed = 1'b0;
                while (w < LIM && !ok[w]) begin
`ifdef ROUND_SCHED_TIMEOUT_EN
                    if (w - launch == TO) begin
                        timed = 1'b1;
                        break;
                    end
`endif
                    w++;
                end
                if (w >= LIM) break;
                if (timed) begin
                    done_c = w + 1;
                    err_x = 1'b1;
                    break;
                end
                if (w + 1 < LIM) e_pull[w + 1] = 1'b1;
                if (r == int'(rounds) - 1) done_c = w + 2;
                else launch = w + 2;
            end
        end
        if (abort_c >= 1 && abort_c < LIM && (done_c < 0 || abort_c < done_c)) begin
            for (int c = abort_c + 1; c < LIM; c++) begin
                e_sync[c] = 1'b0; e_tx[c] = 1'b0; e_pull[c] = 1'b0;
            end
            done_c = abort_c + 1;
            err_x = 1'b1;
        end
        if (done_c >= 0 && done_c < LIM) e_done[done_c] = 1'b1;
        for (int c = 1; c < LIM; c++) e_busy[c] = (done_c < 0) || (c <= done_c);
        for (int c = last + 1; c < LIM; c++) begin
            e_sync[c] = 1'b0; e_tx[c] = 1'b0; e_pull[c] = 1'b0;
            e_done[c] = 1'b0; e_busy[c] = 1'b0;
        end

        check({name, "_gen_sync"}, o_sync, e_sync);
        check({name, "_tx_start"}, o_tx, e_tx);
        check({name, "_rx_pull"},  o_pull, e_pull);
        check({name, "_done"},     o_done, e_done);
        check({name, "_busy"},     o_busy, e_busy);

        bad = -1; pc = 0; bo = '0; be = '0;
        for (int c = 1; c <= last; c++) begin
            if (c == last && bad < 0) begin
                bo = o_cnt[c]; be = RW'(pc);
            end
            if (bad < 0 && o_cnt[c] !== RW'(pc)) begin
                bad = c; bo = o_cnt[c]; be = RW'(pc);
            end
            if (e_pull[c]) pc++;
        end
        check({name, "_round_cnt"}, LIM'(bo), LIM'(be));

        bad = -1; eo = 1'b0; ee = 1'b0;
        for (int c = 1; c <= last; c++) begin
            logic ex;
            ex = (done_c >= 0 && c >= done_c) ? err_x : 1'b0;
            if (c == last && bad < 0) begin
                eo = o_err[c]; ee = ex;
            end
            if (bad < 0 && o_err[c] !== ex) begin
                bad = c; eo = o_err[c]; ee = ex;
            end
        end
        check({name, "_err"}, LIM'(eo), LIM'(ee));

        done_at = dseen;
        cnt_end = o_cnt[last];
        err_end = o_err[last];
    endtask

    initial begin
        int            dat;
        logic [RW-1:0] cnt;
        logic          err;
        int            ab;
        logic [GN-1:0] m;

        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_rounds = '0; bus.i_gate_en = '0; bus.i_abort = 1'b0;
        bus.i_tx_ready = '0; bus.i_rx_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",     LIM'(bus.o_busy),      '0);
        check("reset_gen_sync", LIM'(bus.o_gen_sync),  '0);
        check("reset_tx_start", LIM'(bus.o_tx_start),  '0);
        check("reset_rx_pull",  LIM'(bus.o_rx_pull),   '0);
        check("reset_done",     LIM'(bus.o_done),      '0);
        check("reset_cnt",      LIM'(bus.o_round_cnt), '0);
        check("reset_err",      LIM'(bus.o_err),       '0);
        rst = 1'b0;

        // Three rounds, everything ready: sync 1, tx 2/5/8, pull 4/7/10, done 11.
        run_job("t1", 16'd3, 8'hFF, 1'b1, 8'hFF, -1, dat, cnt, err);
        check("t1_done_cycle", LIM'(dat), LIM'(11));
        check("t1_cnt", LIM'(cnt), LIM'(3));
        check("t1_err", LIM'(err), '0);

        // Zero rounds: done at cycle 1, nothing else.
        run_job("t2", 16'd0, 8'hFF, 1'b1, 8'hFF, -1, dat, cnt, err);
        check("t2_done_cycle", LIM'(dat), LIM'(1));
        check("t2_cnt", LIM'(cnt), '0);

        // Masked-off gate 5 never ready.
        run_job("t3", 16'd1, 8'h03, 1'b1, 8'hDF, -1, dat, cnt, err);
        check("t3_cnt", LIM'(cnt), LIM'(1));
        check("t3_err", LIM'(err), '0);

        // Abort in the first WAIT while all gates are ready.
        run_job("t4", 16'd2, 8'hFF, 1'b1, 8'hFF, 3, dat, cnt, err);
        check("t4_done_cycle", LIM'(dat), LIM'(4));
        check("t4_err", LIM'(err), LIM'(1));
        check("t4_cnt", LIM'(cnt), '0);
        run_job("t4b", 16'd1, 8'hFF, 1'b1, 8'hFF, -1, dat, cnt, err);
        check("t4b_err_cleared", LIM'(err), '0);

        // Gate 0 never ready.
        run_job("t5", 16'd1, 8'h01, 1'b1, 8'hFE, -1, dat, cnt, err);
`ifdef ROUND_SCHED_TIMEOUT_EN
        check("t5_done_cycle", LIM'(dat), LIM'(2 + TO + 1));
        check("t5_err", LIM'(err), LIM'(1));
        check("t5_cnt", LIM'(cnt), '0);
`else
        check("t5_no_done", LIM'(dat), LIM'(-1));
        check("t5_still_busy", LIM'(bus.o_busy), LIM'(1));
        drive(1'b0, '0, '0, 1'b1, 8'h00);
        drive(1'b0, '0, '0, 1'b0, 8'h00);
        check("t5_abort_done", LIM'(bus.o_done), LIM'(1));
        check("t5_abort_err", LIM'(bus.o_err), LIM'(1));
`endif
        drive(1'b0, '0, '0, 1'b0, 8'h00);
        check("t5_idle", LIM'(bus.o_busy), '0);

        // Reset during the WAIT of round 2, plus a request while busy.
        drive(1'b1, 16'd3, 8'hFF, 1'b0, 8'hFF);   // c0
        drive(1'b0, 16'd3, 8'hFF, 1'b0, 8'hFF);   // c1 SYNC
        drive(1'b0, 16'd3, 8'hFF, 1'b0, 8'hFF);   // c2 LAUNCH
        drive(1'b1, 16'd0, 8'hFF, 1'b0, 8'hFF);   // c3 WAIT, req ignored
        drive(1'b0, 16'd0, 8'hFF, 1'b0, 8'h00);   // c4 PULL
        check("t6_pull",       LIM'(bus.o_rx_pull), LIM'(1));
        check("t6_req_ignored", LIM'(bus.o_done),   '0);
        drive(1'b0, 16'd0, 8'hFF, 1'b0, 8'h00);   // c5 LAUNCH
        check("t6_launch2", LIM'(bus.o_tx_start), LIM'(1));
        drive(1'b0, 16'd0, 8'hFF, 1'b0, 8'h00);   // c6 WAIT
        drive(1'b0, 16'd0, 8'hFF, 1'b0, 8'h00);   // c7 WAIT
        check("t6_cnt_before", LIM'(bus.o_round_cnt), LIM'(1));
        check("t6_busy_before", LIM'(bus.o_busy), LIM'(1));
        rst = 1'b1;
        drive(1'b0, 16'd0, 8'hFF, 1'b0, 8'h00);   // c8
        rst = 1'b0;
        check("t6_busy_after", LIM'(bus.o_busy), '0);
        check("t6_cnt_after",  LIM'(bus.o_round_cnt), '0);
        check("t6_done_after", LIM'(bus.o_done), '0);
        drive(1'b0, 16'd0, 8'hFF, 1'b0, 8'hFF);   // c9
        check("t6_no_done", LIM'({bus.o_done, bus.o_busy, bus.o_tx_start}), '0);

        // Randomised jobs: rounds, mask, readiness, mid-job input noise, aborts.
        for (int j = 0; j < 25; j++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1;
            m  = ($urandom_range(0, 7) == 0) ? '0 : GN'($urandom);
            run_job($sformatf("rnd%0d", j), RW'($urandom_range(0, 6)), m, 1'b0, '0,
                    ab, dat, cnt, err);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
